remote_cmd_seq: RTL and testbench
=================================

# remote_cmd_seq

Parametrised command sequencer that sits between a command source (bench stimulus or on-board host logic) and `RemoteComm`. It buffers a queue of 16-bit commands and issues each one through the `snd_cmd`/`cmd_snt` handshake. For each command it collects the stream of responses: `0x5A` for intermediate move acks, terminated by `0xA5` as the positive ack. Every response is checked against a per-command limit and a per-response timeout, and a sticky error is raised on any violation.

## Interface
Parameters:
- `CMD_W`, 16, command width.
- `RESP_W`, 8, response width.
- `DEPTH`, 8, command FIFO depth; power of two, ≥2.
- `CNT_W`, 8, width of the per-command intermediate-ack limit and counter.
- `TMO_W`, 24, timeout counter width.
- `TMO_CYC`, 24'd1_000_000, cycles allowed per response; must be < 2^TMO_W.
- `POS_ACK`, 8'hA5, terminating response.
- `MOVE_ACK`, 8'h5A, intermediate response.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `push` in 1: enqueue `{push_cmd, push_lim}`; ignored while `full`.
- `push_cmd` in CMD_W: command to send.
- `push_lim` in CNT_W: maximum `MOVE_ACK`s allowed before `POS_ACK`.
- `full`, `empty` out 1: FIFO status.
- `go` in 1: start draining the queue; sampled in IDLE only.
- `clr_err` in 1: clears the sticky error and returns to IDLE.
- `cmd` out CMD_W; `snd_cmd` out 1; `cmd_snt` in 1: to/from `RemoteComm`.
- `resp_rdy` in 1; `resp` in RESP_W: from `RemoteComm`.
- `busy` out 1; `done` out 1 (one-cycle pulse); `err` out 1 (sticky); `err_code` out 2; `ack_cnt` out CNT_W (MOVE_ACKs for the current command).

## Operation
- FIFO: circular buffer with read/write pointers of log2(DEPTH)+1 bits; full/empty derived from pointer MSB compare. Push and pop in the same cycle are both honoured; push while full is dropped; the pointers are left unchanged.
- States: IDLE, LOAD, SEND, WAIT_SNT, WAIT_RESP, DONE, ERR.
- IDLE: `go` with FIFO not empty → LOAD. `go` while empty → DONE (pulse `done`, no send).
- LOAD: pop head into the `cmd`/limit registers; clear `ack_cnt` and the timer → SEND.
- SEND: assert `snd_cmd` for exactly one cycle → WAIT_SNT.
- WAIT_SNT: wait for `cmd_snt`; the timer runs. Timer reaching TMO_CYC → ERR, `err_code`=2'b00 (send timeout). On `cmd_snt`, clear the timer → WAIT_RESP.
- WAIT_RESP handles each `resp_rdy` as follows:
  - `resp`==MOVE_ACK with `ack_cnt`<limit: `ack_cnt`++, clear the timer, stay.
  - `resp`==MOVE_ACK with `ack_cnt`==limit → ERR, code 2'b10 (too many acks).
  - `resp`==POS_ACK: FIFO empty → DONE, else → LOAD.
  - Any other value → ERR, code 2'b01 (bad response).
  - No `resp_rdy` within TMO_CYC cycles since the last event → ERR, code 2'b11.
- DONE: pulse `done` one cycle → IDLE.
- ERR: `err`=1, hold `err_code`; remaining FIFO entries are kept. `clr_err` → IDLE with `err`=0. `clr_err` outside ERR is ignored.
- Simultaneous timer expiry and `resp_rdy` in the same cycle: the response wins.
- `cmd_snt` arriving in SEND (one cycle early) is ignored. `resp_rdy` outside WAIT_RESP is ignored.

## Timing
- Reset values: FIFO empty (`empty`=1, `full`=0), state IDLE; `snd_cmd`, `busy`, `done`, `err` all 0; `err_code`=0, `cmd`=0, `ack_cnt`=0.
- Reset mid-operation discards the queue and the in-flight command; `snd_cmd` drops in the same cycle (asynchronous).
- `go` → `snd_cmd` high: 2 cycles (IDLE→LOAD→SEND). `snd_cmd` is registered.
- `busy`=1 in every state except IDLE.
- POS_ACK → next `snd_cmd`: 2 cycles. POS_ACK with FIFO empty → `done` on the next cycle.
- Timer counts saturating at TMO_W bits; expiry is compared at ==TMO_CYC.

## Structure
- Package `rcs_pkg`: state enum `rcs_state_t`, `err_code` localparams (`ERR_SND_TMO`, `ERR_BAD_RESP`, `ERR_TOO_MANY`, `ERR_RESP_TMO`), and the default POS_ACK/MOVE_ACK constants.
- Sub-module `rcs_fifo` (parametrised CMD_W+CNT_W by DEPTH, registered output). The FSM, timer and counter live in `remote_cmd_seq`.

## Test plan
- Push `0x2000`/lim 0, `go`; respond `cmd_snt` then `0xA5` → one `snd_cmd` with `cmd`=0x2000, `done` pulse, `err`=0.
- Push `0x6020`/lim 48; respond 48×`0x5A` then `0xA5` → `ack_cnt` reaches 48, no error, `done`.
- Push 3 commands, respond normally to each → three `snd_cmd` pulses in FIFO order; next `snd_cmd` is 2 cycles after each `0xA5`.
- Lim 1, respond `0x5A`,`0x5A` → ERR, code 2'b10. Respond `0x33` → code 2'b01. `clr_err` → IDLE, `err`=0, remaining entries still queued.
- TMO_CYC=100, never assert `resp_rdy` → ERR code 2'b11 at exactly cycle 100 after `cmd_snt`. `resp_rdy` at cycle 100 → accepted, no error.
- Push DEPTH+1 entries → `full` after DEPTH pushes, extra entry dropped. Assert `rst` mid-WAIT_RESP → `empty`=1, `busy`=0, `snd_cmd`=0 immediately.

Source files
------------

// File: rtl/rcs_pkg.sv
// rtl/rcs_pkg.sv - shared types and constants for the remote command sequencer
package rcs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_DONE,
    S_ERR
  } rcs_state_t;

  localparam logic [1:0] ERR_SND_TMO  = 2'b00;
  localparam logic [1:0] ERR_BAD_RESP = 2'b01;
  localparam logic [1:0] ERR_TOO_MANY = 2'b10;
  localparam logic [1:0] ERR_RESP_TMO = 2'b11;

  localparam logic [7:0] DEF_POS_ACK  = 8'hA5;
  localparam logic [7:0] DEF_MOVE_ACK = 8'h5A;

endpackage

// File: rtl/rcs_fifo.sv
// rtl/rcs_fifo.sv - circular command queue with registered read data
module rcs_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes a wrapped (full) queue from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rdata  <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/remote_cmd_seq.sv
// rtl/remote_cmd_seq.sv - queues commands and walks each through send, ack collection and timeout checks
module remote_cmd_seq
  import rcs_pkg::*;
#(
  parameter int                CMD_W    = 16,
  parameter int                RESP_W   = 8,
  parameter int                DEPTH    = 8,
  parameter int                CNT_W    = 8,
  parameter int                TMO_W    = 24,
  parameter logic [TMO_W-1:0]  TMO_CYC  = 24'd1_000_000,
  parameter logic [RESP_W-1:0] POS_ACK  = DEF_POS_ACK,
  parameter logic [RESP_W-1:0] MOVE_ACK = DEF_MOVE_ACK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CMD_W-1:0]  push_cmd,
  input  logic [CNT_W-1:0]  push_lim,
  output logic              full,
  output logic              empty,
  input  logic              go,
  input  logic              clr_err,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  ack_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMR_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  rcs_state_t             state, next;
  logic [CMD_W+CNT_W-1:0] head;
  logic [CNT_W-1:0]       lim;
  logic [TMO_W-1:0]       tmr;
  logic                   tmr_clr;
  logic                   cnt_inc;
  logic [1:0]             code_nxt;

  // The FIFO read register doubles as the in-flight command/limit holding register.
  rcs_fifo #(.W(CMD_W + CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_cmd, push_lim}),
    .pop   (state == S_LOAD),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd  = head[CMD_W+CNT_W-1:CNT_W];
  assign lim  = head[CNT_W-1:0];
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  always_comb begin
    next     = state;
    tmr_clr  = 1'b0;
    cnt_inc  = 1'b0;
    code_nxt = err_code;
    case (state)
      S_IDLE:    if (go) next = empty ? S_DONE : S_LOAD;
      S_LOAD:    begin next = S_SEND; tmr_clr = 1'b1; end
      S_SEND:    begin next = S_WAIT_SNT; tmr_clr = 1'b1; end
      S_WAIT_SNT: begin
        if (cmd_snt) begin
          next    = S_WAIT_RESP;
          tmr_clr = 1'b1;
        end else if (tmr == TMO_CYC) begin
          next     = S_ERR;
          code_nxt = ERR_SND_TMO;
        end
      end
      S_WAIT_RESP: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (resp_rdy) begin
          if (resp == MOVE_ACK) begin
            if (ack_cnt == lim) begin
              next     = S_ERR;
              code_nxt = ERR_TOO_MANY;
            end else begin
              cnt_inc = 1'b1;
              tmr_clr = 1'b1;
            end
          end else if (resp == POS_ACK) begin
            next = empty ? S_DONE : S_LOAD;
          end else begin
            next     = S_ERR;
            code_nxt = ERR_BAD_RESP;
          end
        end else if (tmr == TMO_CYC) begin
          next     = S_ERR;
          code_nxt = ERR_RESP_TMO;
        end
      end
      S_DONE:  next = S_IDLE;
      S_ERR:   if (clr_err) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      snd_cmd  <= 1'b0;
      err_code <= '0;
      ack_cnt  <= '0;
      tmr      <= '0;
    end else begin
      state    <= next;
      snd_cmd  <= (next == S_SEND);
      err_code <= code_nxt;
      if (state == S_LOAD)  ack_cnt <= '0;
      else if (cnt_inc)     ack_cnt <= ack_cnt + CNT_ONE;
      if (tmr_clr)          tmr <= '0;
      else if ((state == S_WAIT_SNT || state == S_WAIT_RESP) && tmr != '1)
        tmr <= tmr + TMR_ONE;
    end
  end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb/tb_remote_cmd_seq.sv - directed vector bench for remote_cmd_seq
module tb_remote_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_cmd = '0;
  logic [7:0]  push_lim = '0;
  logic        full, empty;
  logic        go = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  ack_cnt;

  int checks = 0;
  int errors = 0;

  remote_cmd_seq #(.DEPTH(4), .TMO_CYC(24'd100)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_lim(push_lim),
    .full(full), .empty(empty), .go(go), .clr_err(clr_err), .cmd(cmd),
    .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [7:0]  lim;
    int          moves;
    logic        term_en;
    logic [7:0]  term;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_ack;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_one(input logic [15:0] c, input logic [7:0] l);
    push = 1'b1; push_cmd = c; push_lim = l;
    tick();
    push = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] r);
    resp = r; resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic start_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Entered one cycle after go or POS_ACK was sampled (state LOAD); leaves in WAIT_RESP.
  task automatic serve(input logic [15:0] exp_cmd);
    chk("snd_cmd_low_in_load", snd_cmd, 1'b0);
    tick();
    chk("snd_cmd_high", snd_cmd, 1'b1);
    chk("cmd_value", cmd, exp_cmd);
    tick();
    chk("snd_cmd_one_cycle", snd_cmd, 1'b0);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
  endtask

  task automatic clear_error();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_cleared", err, 1'b0);
    chk("idle_after_clr", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{16'h2000, 8'd0,  0, 1'b1, 8'hA5, 1'b0, 2'b00, 8'd0};
    vecs[1] = '{16'h6020, 8'd48, 48, 1'b1, 8'hA5, 1'b0, 2'b00, 8'd48};
    vecs[2] = '{16'h1234, 8'd1,  2, 1'b0, 8'h00, 1'b1, 2'b10, 8'd1};
    vecs[3] = '{16'h4321, 8'd3,  1, 1'b1, 8'h33, 1'b1, 2'b01, 8'd1};
    vecs[4] = '{16'h0F0F, 8'd2,  2, 1'b1, 8'hA5, 1'b0, 2'b00, 8'd2};
    vecs[5] = '{16'hBEEF, 8'd0,  0, 1'b1, 8'h00, 1'b1, 2'b01, 8'd0};

    tick();
    tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_snd_cmd", snd_cmd, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_ack_cnt", ack_cnt, 8'd0);
    rst = 1'b0;
    tick();

    // go with an empty queue: done pulse, no send
    start_go();
    chk("empty_go_done", done, 1'b1);
    chk("empty_go_no_send", snd_cmd, 1'b0);
    tick();
    chk("empty_go_idle", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].c, vecs[i].lim);
      start_go();
      serve(vecs[i].c);
      for (int m = 0; m < vecs[i].moves; m++) send_resp(8'h5A);
      if (vecs[i].term_en) send_resp(vecs[i].term);
      chk("vec_err", err, vecs[i].exp_err);
      chk("vec_ack_cnt", ack_cnt, vecs[i].exp_ack);
      if (vecs[i].exp_err) begin
        chk("vec_err_code", err_code, vecs[i].exp_code);
        clear_error();
      end else begin
        chk("vec_done", done, 1'b1);
        tick();
        chk("vec_done_pulse", done, 1'b0);
        chk("vec_idle", busy, 1'b0);
      end
    end

    // three queued commands drained in order, 2 cycles from POS_ACK to next send
    push_one(16'hA001, 8'd0);
    push_one(16'hB002, 8'd0);
    push_one(16'hC003, 8'd0);
    start_go();
    serve(16'hA001);
    send_resp(8'hA5);
    serve(16'hB002);
    send_resp(8'hA5);
    serve(16'hC003);
    send_resp(8'hA5);
    chk("chain_done", done, 1'b1);
    tick();

    // error leaves remaining entries queued
    push_one(16'h1111, 8'd1);
    push_one(16'h2222, 8'd0);
    start_go();
    serve(16'h1111);
    send_resp(8'h5A);
    send_resp(8'h5A);
    chk("keep_err", err, 1'b1);
    chk("keep_err_code", err_code, 2'b10);
    chk("keep_not_empty", empty, 1'b0);
    clear_error();
    start_go();
    serve(16'h2222);
    send_resp(8'hA5);
    chk("keep_done", done, 1'b1);
    tick();

    // response timeout at the boundary
    push_one(16'h3333, 8'd0);
    start_go();
    serve(16'h3333);
    repeat (100) tick();
    chk("rtmo_not_yet", err, 1'b0);
    tick();
    chk("rtmo_err", err, 1'b1);
    chk("rtmo_code", err_code, 2'b11);
    clear_error();

    // response in the expiry cycle is accepted
    push_one(16'h4444, 8'd0);
    start_go();
    serve(16'h4444);
    repeat (100) tick();
    send_resp(8'hA5);
    chk("rlate_no_err", err, 1'b0);
    chk("rlate_done", done, 1'b1);
    tick();

    // early cmd_snt during SEND is ignored, then send timeout
    push_one(16'h5555, 8'd0);
    start_go();
    tick();
    chk("stmo_send", snd_cmd, 1'b1);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (100) tick();
    chk("stmo_not_yet", err, 1'b0);
    tick();
    chk("stmo_err", err, 1'b1);
    chk("stmo_code", err_code, 2'b00);
    clear_error();

    // fill to DEPTH, extra push dropped
    push_one(16'hD000, 8'd0);
    push_one(16'hD001, 8'd0);
    push_one(16'hD002, 8'd0);
    chk("fill_not_full", full, 1'b0);
    push_one(16'hD003, 8'd0);
    chk("fill_full", full, 1'b1);
    push_one(16'hDEAD, 8'd0);
    chk("fill_still_full", full, 1'b1);
    start_go();
    for (int k = 0; k < 4; k++) begin
      serve(16'hD000 + 16'(k));
      send_resp(8'hA5);
    end
    chk("fill_dropped_done", done, 1'b1);
    chk("fill_dropped_empty", empty, 1'b1);
    tick();

    // asynchronous reset while snd_cmd is high
    push_one(16'h6666, 8'd0);
    push_one(16'h7777, 8'd0);
    start_go();
    tick();
    chk("arst_pre_snd", snd_cmd, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_snd_drop", snd_cmd, 1'b0);
    chk("arst_send_empty", empty, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // asynchronous reset mid WAIT_RESP
    push_one(16'h8888, 8'd0);
    push_one(16'h9999, 8'd0);
    start_go();
    serve(16'h8888);
    send_resp(8'h5A);
    chk("arst_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_snd", snd_cmd, 1'b0);
    chk("arst_ack_cnt", ack_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
